usb_crc_checker: RTL and testbench

- Streaming, parametrised CRC checker for USB receive packets.
- Accepts decoded packet bytes one per clock, from the first byte after PID through the last CRC byte.
- Runs a bit-serial-equivalent LFSR over data plus transmitted CRC and compares the final register against the fixed residue.
- One instance with CRC_W=5 checks tokens; one with CRC_W=16 checks data packets. It sits between the byte assembler and the packet-decode FSM.

---
 rtl/usb_crc_checker.sv | 140 ++++++++++++++
 tb/tb_usb_crc_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_crc_checker.sv
// Streaming CRC5/CRC16 residue checker for USB receive packets.
// Define CRC_ERR_COUNT_EN to build the saturating error counter.
module usb_crc_checker #(
    parameter int          CRC_W     = 16,
    parameter logic [15:0] POLY      = 16'h8005,
    parameter logic [15:0] INIT      = 16'hFFFF,
    parameter logic [15:0] RESIDUE   = 16'h800D,
    parameter int          MIN_BYTES = 3
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        sop,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic        eop,
    output logic        busy,
    output logic        crc_done,
    output logic        crc_valid,
    output logic        crc_error,
    output logic [10:0] byte_count,
    output logic [7:0]  err_count
);

    localparam logic [CRC_W-1:0] P_W   = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] I_W   = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] R_W   = RESIDUE[CRC_W-1:0];
    localparam logic [10:0]      MIN_B = 11'(MIN_BYTES);
    localparam logic [10:0]      CNT_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        CHECK,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [CRC_W-1:0] crc_q, crc_nx;
    logic [10:0]      cnt_q, cnt_nx;
    logic             valid_q, valid_nx;
    logic             err_q, err_nx;
    logic             pkt_ok;

    // Eight serial LFSR steps, LSB of the byte first on the wire.
    function automatic logic [CRC_W-1:0] crc_byte(
        input logic [CRC_W-1:0] c,
        input logic [7:0]       d
    );
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = d[i] ^ r[CRC_W-1];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? P_W : '0);
        end
        return r;
    endfunction

    assign pkt_ok = (crc_q == R_W) && (cnt_q >= MIN_B);

    always_comb begin
        state_nx = state;
        crc_nx   = crc_q;
        cnt_nx   = cnt_q;
        valid_nx = valid_q;
        err_nx   = err_q;
        unique case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (sop) begin
                    state_nx = ACCUM;
                    crc_nx   = I_W;
                    cnt_nx   = '0;
                    valid_nx = 1'b0;
                    err_nx   = 1'b0;
                end
            end
            ACCUM: begin
                if (sop) begin
                    // Abort: this cycle's byte opens the new packet.
                    crc_nx = data_valid ? crc_byte(I_W, data_in) : I_W;
                    cnt_nx = data_valid ? 11'd1 : 11'd0;
                end else begin
                    if (data_valid) begin
                        crc_nx = crc_byte(crc_q, data_in);
                        if (cnt_q != CNT_MAX)
                            cnt_nx = cnt_q + 11'd1;
                    end
                    if (eop)
                        state_nx = CHECK;
                end
            end
            CHECK: begin
                state_nx = DONE;
                valid_nx = pkt_ok;
                err_nx   = ~pkt_ok;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            crc_q   <= I_W;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            crc_q   <= crc_nx;
            cnt_q   <= cnt_nx;
            valid_q <= valid_nx;
            err_q   <= err_nx;
        end
    end

`ifdef CRC_ERR_COUNT_EN
    logic [7:0] ecnt_q;

    // Counted on the CHECK->DONE edge so it is current during crc_done.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            ecnt_q <= '0;
        else if (state == CHECK && !pkt_ok && ecnt_q != 8'hFF)
            ecnt_q <= ecnt_q + 8'd1;
    end

    assign err_count = ecnt_q;
`else
    assign err_count = 8'h00;
`endif

    assign busy       = (state == ACCUM) || (state == CHECK);
    assign crc_done   = (state == DONE);
    assign crc_valid  = valid_q;
    assign crc_error  = err_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_usb_crc_checker.sv
// Scoreboard bench for usb_crc_checker: one CRC5 and two CRC16 instances.
// Expected results are queued at eop and consumed on each crc_done.
module tb_usb_crc_checker;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [2:0]  sop;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        eop;
    logic        busy [3];
    logic        done [3];
    logic        cv   [3];
    logic        ce   [3];
    logic [10:0] bc   [3];
    logic [7:0]  ec   [3];

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int ecm [3];

    typedef struct {
        int          id;
        logic        v;
        logic        e;
        logic [10:0] n;
        logic [7:0]  ec;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    usb_crc_checker #(
        .CRC_W(5), .POLY(16'h0005), .INIT(16'hFFFF),
        .RESIDUE(16'h000C), .MIN_BYTES(2)
    ) u5 (
        .clk(clk), .n_rst(n_rst), .sop(sop[0]),
        .data_in(data_in), .data_valid(data_valid), .eop(eop),
        .busy(busy[0]), .crc_done(done[0]),
        .crc_valid(cv[0]), .crc_error(ce[0]),
        .byte_count(bc[0]), .err_count(ec[0])
    );

    usb_crc_checker #(
        .CRC_W(16), .POLY(16'h8005), .INIT(16'hFFFF),
        .RESIDUE(16'h800D), .MIN_BYTES(2)
    ) u16a (
        .clk(clk), .n_rst(n_rst), .sop(sop[1]),
        .data_in(data_in), .data_valid(data_valid), .eop(eop),
        .busy(busy[1]), .crc_done(done[1]),
        .crc_valid(cv[1]), .crc_error(ce[1]),
        .byte_count(bc[1]), .err_count(ec[1])
    );

    usb_crc_checker #(
        .CRC_W(16), .POLY(16'h8005), .INIT(16'hFFFF),
        .RESIDUE(16'h800D), .MIN_BYTES(3)
    ) u16b (
        .clk(clk), .n_rst(n_rst), .sop(sop[2]),
        .data_in(data_in), .data_valid(data_valid), .eop(eop),
        .busy(busy[2]), .crc_done(done[2]),
        .crc_valid(cv[2]), .crc_error(ce[2]),
        .byte_count(bc[2]), .err_count(ec[2])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Called in the eop cycle; the strobe is due two cycles later.
    task automatic expect_res(input int id, input bit good, input int n);
        exp_t e;
`ifdef CRC_ERR_COUNT_EN
        if (!good && ecm[id] < 255)
            ecm[id]++;
`endif
        e.id  = id;
        e.v   = good;
        e.e   = !good;
        e.n   = 11'(n);
        e.ec  = 8'(ecm[id]);
        e.cyc = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic pkt(input int id, input logic [7:0] b[$],
                       input bit eop_last, input bit good);
        sop[id] = 1'b1;
        step();
        sop = '0;
        chk("sop_clr_valid", 32'(cv[id]), 0);
        chk("sop_clr_error", 32'(ce[id]), 0);
        chk("sop_busy", 32'(busy[id]), 1);
        foreach (b[i]) begin
            data_valid = 1'b1;
            data_in    = b[i];
            if (eop_last && i == b.size() - 1) begin
                eop = 1'b1;
                expect_res(id, good, b.size());
            end
            step();
        end
        data_valid = 1'b0;
        data_in    = '0;
        if (!eop_last) begin
            eop = 1'b1;
            expect_res(id, good, b.size());
            step();
        end
        eop = 1'b0;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) begin
                int k;
                k = -1;
                foreach (sb[j])
                    if (k < 0 && sb[j].id == i)
                        k = j;
                if (k < 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: inst %0d cyc %0d",
                             i, cyc);
                end else begin
                    chk("done_cycle", cyc, sb[k].cyc);
                    chk("crc_valid", 32'(cv[i]), 32'(sb[k].v));
                    chk("crc_error", 32'(ce[i]), 32'(sb[k].e));
                    chk("byte_count", 32'(bc[i]), 32'(sb[k].n));
                    chk("err_count", 32'(ec[i]), 32'(sb[k].ec));
                    chk("busy_in_done", 32'(busy[i]), 0);
                    sb.delete(k);
                end
            end
        end
    end

    initial begin
        n_rst      = 1'b0;
        sop        = '0;
        data_in    = '0;
        data_valid = 1'b0;
        eop        = 1'b0;
        for (int i = 0; i < 3; i++) ecm[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 32'(busy[i]), 0);
            chk("rst_done", 32'(done[i]), 0);
            chk("rst_valid", 32'(cv[i]), 0);
            chk("rst_error", 32'(ce[i]), 0);
            chk("rst_count", 32'(bc[i]), 0);
            chk("rst_errcnt", 32'(ec[i]), 0);
        end
        n_rst = 1'b1;
        step();
        step();

        // SETUP addr 0 endp 0, good token; eop after last byte
        pkt(0, '{8'h00, 8'h10}, 1'b0, 1'b1);
        repeat (4) step();
        chk("hold_valid", 32'(cv[0]), 1);
        chk("hold_count", 32'(bc[0]), 2);

        // Single-bit flip; eop with the last byte
        pkt(0, '{8'h00, 8'h11}, 1'b1, 1'b0);
        repeat (4) step();

        // Zero-length DATA0, MIN_BYTES=2 and MIN_BYTES=3
        pkt(1, '{8'h00, 8'h00}, 1'b1, 1'b1);
        repeat (4) step();
        pkt(2, '{8'h00, 8'h00}, 1'b0, 1'b0);
        repeat (4) step();

        // One-byte token is too short
        pkt(0, '{8'h00}, 1'b0, 1'b0);
        repeat (4) step();

        // Abort after 3 bytes; restart byte comes with sop
        sop[1] = 1'b1;
        step();
        sop = '0;
        data_valid = 1'b1;
        data_in = 8'h12;
        step();
        data_in = 8'h34;
        step();
        data_in = 8'h56;
        step();
        sop[1]  = 1'b1;
        data_in = 8'h00;
        step();
        sop = '0;
        eop = 1'b1;
        expect_res(1, 1'b1, 2);
        step();
        eop = 1'b0;
        data_valid = 1'b0;
        repeat (4) step();
        chk("abort_count", 32'(bc[1]), 2);

        // Back-to-back: each sop lands in the previous DONE cycle
        pkt(1, '{8'h00, 8'h00}, 1'b1, 1'b1);
        step();
        pkt(1, '{8'h00, 8'h01}, 1'b1, 1'b0);
        step();
        pkt(1, '{8'h00, 8'h00}, 1'b0, 1'b1);
        repeat (4) step();

        // Reset mid-packet after two bytes
        sop[1] = 1'b1;
        step();
        sop = '0;
        data_valid = 1'b1;
        data_in = 8'h00;
        step();
        step();
        data_valid = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy[1]), 0);
        chk("mid_rst_valid", 32'(cv[1]), 0);
        chk("mid_rst_error", 32'(ce[1]), 0);
        chk("mid_rst_count", 32'(bc[1]), 0);
        chk("mid_rst_errcnt", 32'(ec[0]), 0);
        for (int i = 0; i < 3; i++) ecm[i] = 0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        step();
        pkt(1, '{8'h00, 8'h00}, 1'b1, 1'b1);
        repeat (4) step();
        pkt(0, '{8'h00, 8'h11}, 1'b0, 1'b0);
        repeat (4) step();
        pkt(0, '{8'h00, 8'h10}, 1'b1, 1'b1);
        repeat (6) step();

        chk("missing_done", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
